// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter and its line synchroniser.
package ps2_host_tx_pkg;

  // Transmitter FSM state encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // Keyboard command / response bytes
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  // Odd parity bit for a PS/2 frame: total ones in data+parity is odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pins plus falling-edge
// detection on the synchronised clock. Reset value is the idle (high) level.
module ps2_host_tx_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_pin,
  input  logic data_pin,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff_reg;
  logic [1:0] data_ff_reg;
  logic       clk_prev_reg;

  // Synchronise both pins and remember the previous synced clock level
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_ff_reg   <= 2'b11;
      data_ff_reg  <= 2'b11;
      clk_prev_reg <= 1'b1;
    end else begin
      clk_ff_reg   <= {clk_ff_reg[0], clk_pin};
      data_ff_reg  <= {data_ff_reg[0], data_pin};
      clk_prev_reg <= clk_ff_reg[1];
    end
  end

  assign clk_sync  = clk_ff_reg[1];
  assign data_sync = data_ff_reg[1];
  assign clk_fall  = clk_prev_reg & ~clk_ff_reg[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts one byte out on device clock falls and checks the device ACK.
// Line outputs are drive-low enables for open-drain pins.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYC = 12000,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_drive_low,
  output logic       ps2data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  logic             clk_sync;
  logic             data_sync;
  logic             clk_fall;

  logic [2:0]       state_reg;
  logic [7:0]       data_reg;
  logic             parity_reg;
  logic [3:0]       bit_cnt_reg;
  logic [INH_W-1:0] inh_cnt_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic             clk_low_reg;
  logic             data_low_reg;
  logic             done_reg;
  logic             ack_err_reg;
  logic             timeout_err_reg;
  logic             to_hit;

  ps2_host_tx_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .clk_pin   (ps2clk_in),
    .data_pin  (ps2data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  assign to_hit = (to_cnt_reg == TO_LAST);

  // Frame sequencing, bit shifting, ACK check and timeout supervision
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      data_reg        <= '0;
      parity_reg      <= 1'b0;
      bit_cnt_reg     <= '0;
      inh_cnt_reg     <= '0;
      to_cnt_reg      <= '0;
      clk_low_reg     <= 1'b0;
      data_low_reg    <= 1'b0;
      done_reg        <= 1'b0;
      ack_err_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      done_reg        <= 1'b0;
      ack_err_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (tx_valid) begin
            data_reg     <= tx_data;
            parity_reg   <= odd_parity(tx_data);
            bit_cnt_reg  <= '0;
            inh_cnt_reg  <= '0;
            clk_low_reg  <= 1'b1;
            data_low_reg <= 1'b0;
            state_reg    <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (inh_cnt_reg == INH_LAST) begin
            data_low_reg <= 1'b1;
            state_reg    <= ST_REQ;
          end else begin
            inh_cnt_reg <= inh_cnt_reg + 1'b1;
          end
        end
        ST_REQ: begin
          // Release the clock; data stays low as the start bit
          clk_low_reg <= 1'b0;
          to_cnt_reg  <= '0;
          state_reg   <= ST_SEND;
        end
        ST_SEND: begin
          if (clk_fall) begin
            to_cnt_reg  <= '0;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg < 4'd8) begin
              data_low_reg <= ~data_reg[bit_cnt_reg[2:0]];
            end else if (bit_cnt_reg == 4'd8) begin
              data_low_reg <= ~parity_reg;
            end else begin
              data_low_reg <= 1'b0;
              state_reg    <= ST_ACK;
            end
          end else if (to_hit) begin
            clk_low_reg     <= 1'b0;
            data_low_reg    <= 1'b0;
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        ST_ACK: begin
          if (clk_fall) begin
            to_cnt_reg <= '0;
            if (!data_sync) begin
              state_reg <= ST_WAIT_IDLE;
            end else begin
              ack_err_reg <= 1'b1;
              state_reg   <= ST_IDLE;
            end
          end else if (to_hit) begin
            clk_low_reg     <= 1'b0;
            data_low_reg    <= 1'b0;
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_sync && data_sync) begin
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end else if (clk_fall) begin
            to_cnt_reg <= '0;
          end else if (to_hit) begin
            clk_low_reg     <= 1'b0;
            data_low_reg    <= 1'b0;
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        default: begin
          clk_low_reg  <= 1'b0;
          data_low_reg <= 1'b0;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready          = (state_reg == ST_IDLE);
  assign busy              = (state_reg != ST_IDLE);
  assign ps2clk_drive_low  = clk_low_reg;
  assign ps2data_drive_low = data_low_reg;
  assign done              = done_reg;
  assign ack_err           = ack_err_reg;
  assign timeout_err       = timeout_err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 keyboard drives the clock,
// samples host data on rising edges and ACKs on the 11th clock.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 500;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2clk_in;
  logic       ps2data_in;
  logic       clk_dl;
  logic       data_dl;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout_err;

  // Open-drain wired-AND of host and device on each line
  assign ps2clk_in  = dev_clk & ~clk_dl;
  assign ps2data_in = dev_data & ~data_dl;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .ps2clk_in         (ps2clk_in),
    .ps2data_in        (ps2data_in),
    .ps2clk_drive_low  (clk_dl),
    .ps2data_drive_low (data_dl),
    .busy              (busy),
    .done              (done),
    .ack_err           (ack_err),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_done = 0, n_ackerr = 0, n_to = 0, n_accept = 0;
  bit in_frame = 1'b0, reset_prev = 1'b0;
  logic data_dl_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the frame-level model of the host
  always @(negedge clk) begin
    if (done)        n_done++;
    if (ack_err)     n_ackerr++;
    if (timeout_err) n_to++;
    if (done || ack_err || timeout_err || reset_prev) in_frame = 1'b0;
    chk("busy_vs_model", busy, in_frame);
    chk("ready_vs_busy", tx_ready, !busy);
    chk("pulse_exclusive", (int'(done) + int'(ack_err) + int'(timeout_err)) <= 1, 1);
    if (!busy) chk("idle_lines_released", {clk_dl, data_dl}, 2'b00);
    if (data_dl !== data_dl_prev)
      chk("data_change_window", (dev_clk == 1'b0) || clk_dl || !busy, 1);
    data_dl_prev = data_dl;
    if (tx_valid && tx_ready && !reset) begin
      n_accept++;
      in_frame = 1'b1;
    end
    reset_prev = reset;
  end

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  // Keyboard model: waits for request, then generates nclk clock pulses
  task automatic dev_frame(input int nclk, input bit ack, output logic [10:0] bits,
                           output int inh_len);
    int w;
    bits = '1;
    inh_len = 0;
    w = 0;
    while (!clk_dl && w < 5000) begin step(); w++; end
    if (!clk_dl) begin chk("request_seen", 0, 1); return; end
    while (clk_dl && inh_len < 5000) begin step(); inh_len++; end
    bits[0] = ps2data_in;
    repeat (HALF) step();
    for (int i = 1; i <= nclk; i++) begin
      if (i == 11 && ack) dev_data = 1'b0;
      repeat (HALF / 2) step();
      dev_clk = 1'b0;
      repeat (HALF) step();
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = ps2data_in;
      repeat (HALF) step();
      if (i == 11) dev_data = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, output logic [10:0] bits);
    int d0, e0, t0, inh;
    d0 = n_done; e0 = n_ackerr; t0 = n_to;
    fork
      send(b);
      dev_frame(11, ack, bits, inh);
    join
    repeat (10) step();
    chk("inhibit_len", inh >= INH, 1);
    chk("start_bit", bits[0], 0);
    chk("data_byte", bits[8:1], b);
    chk("parity_bit", bits[9], ($countones(b) % 2) == 0);
    chk("stop_bit", bits[10], 1);
    chk("done_pulses", n_done - d0, ack ? 1 : 0);
    chk("ack_err_pulses", n_ackerr - e0, ack ? 0 : 1);
    chk("timeout_pulses", n_to - t0, 0);
    chk("lines_released", {clk_dl, data_dl}, 2'b00);
    chk("ready_after", tx_ready, 1);
    $display("frame %02h ack=%0d bits=%011b", b, ack, bits);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits;
    int cnt, inh, a0, d0, e0, t0;

    // Reset state
    step(); step();
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_lines", {clk_dl, data_dl}, 2'b00);
    chk("rst_pulses", {done, ack_err, timeout_err}, 3'b000);
    reset = 1'b0;
    step();

    // 1: set-LEDs command, full frame pinned by literal
    run_frame(8'hED, 1'b1, bits);
    chk("ed_frame_literal", bits, 11'b11111011010);

    // 2: parity cases
    run_frame(8'h07, 1'b1, bits);
    chk("parity_07_literal", bits[9], 0);
    run_frame(8'hFF, 1'b1, bits);
    chk("parity_ff_literal", bits[9], 1);

    // 3: device withholds ACK
    run_frame(8'h12, 1'b0, bits);

    // 4: device never clocks -> timeout
    d0 = n_done; t0 = n_to;
    send(8'h55);
    cnt = 0;
    while (!clk_dl && cnt < 1000) begin step(); cnt++; end
    while (clk_dl && cnt < 1000) begin step(); cnt++; end
    cnt = 0;
    while (!timeout_err && cnt < 2 * TO) begin step(); cnt++; end
    chk("timeout_seen", timeout_err, 1);
    chk("timeout_latency", (cnt >= TO - 1) && (cnt <= TO + 1), 1);
    chk("timeout_lines", {clk_dl, data_dl}, 2'b00);
    step(); step();
    chk("timeout_count", n_to - t0, 1);
    chk("timeout_no_done", n_done - d0, 0);
    $display("timeout after %0d cycles", cnt);

    // 5: reset during bit 4, then a clean frame
    d0 = n_done; e0 = n_ackerr; t0 = n_to;
    fork
      send(8'hA5);
      dev_frame(5, 1'b0, bits, inh);
    join
    chk("partial_bits", bits[5:1], 5'b00101);
    reset = 1'b1;
    step();
    chk("midreset_lines", {clk_dl, data_dl}, 2'b00);
    chk("midreset_busy", busy, 0);
    reset = 1'b0;
    repeat (5) step();
    chk("midreset_no_pulse", (n_done - d0) + (n_ackerr - e0) + (n_to - t0), 0);
    $display("reset mid-frame released lines");
    run_frame(8'hF4, 1'b1, bits);

    // 6: tx_valid held high across a frame
    a0 = n_accept; d0 = n_done;
    tx_data = 8'h07;
    tx_valid = 1'b1;
    dev_frame(11, 1'b1, bits, inh);
    cnt = 0;
    while (n_done == d0 && cnt < 50) begin step(); cnt++; end
    step(); step();
    chk("hold_done_once", n_done - d0, 1);
    chk("hold_accepts", n_accept - a0, 2);
    chk("hold_frame1", bits[8:1], 8'h07);
    tx_valid = 1'b0;
    dev_frame(11, 1'b1, bits, inh);
    repeat (10) step();
    chk("hold_accepts_final", n_accept - a0, 2);
    chk("hold_done_final", n_done - d0, 2);
    chk("hold_frame2", bits[8:1], 8'h07);
    $display("held valid: accepts=%0d dones=%0d", n_accept - a0, n_done - d0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
